// File: rtl/lbp_engine_param.sv
// Local Binary Pattern engine: scans a 2^IMG_W_LOG2 x 2^IMG_H_LOG2 image held in
// external synchronous memory, fetches each pixel's 3x3 window and emits one
// 8-bit LBP code per pixel over a valid/ready port.
// Optional build macro LBP_BORDER_EN: scan every pixel, border pixels emit code 0
// without fetching. Without it only interior pixels are scanned.
module lbp_engine_param #(
  parameter int IMG_W_LOG2 = 7,
  parameter int IMG_H_LOG2 = 7,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = IMG_W_LOG2 + IMG_H_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  thr_offset,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_req,
  input  logic              gray_ready,
  input  logic [PIX_W-1:0]  gray_data,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              lbp_valid,
  input  logic              lbp_ready,
  output logic              busy,
  output logic              finish
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUT, S_DONE} state_t;

  localparam logic [IMG_W_LOG2-1:0] X_ONE = IMG_W_LOG2'(1);
  localparam logic [IMG_H_LOG2-1:0] Y_ONE = IMG_H_LOG2'(1);
`ifdef LBP_BORDER_EN
  localparam logic [IMG_W_LOG2-1:0] X_MAX = {IMG_W_LOG2{1'b1}};
  localparam logic [IMG_H_LOG2-1:0] Y_MAX = {IMG_H_LOG2{1'b1}};
`else
  // Last interior column/row: all ones except the LSB.
  localparam logic [IMG_W_LOG2-1:0] X_LAST = {{(IMG_W_LOG2-1){1'b1}}, 1'b0};
  localparam logic [IMG_H_LOG2-1:0] Y_LAST = {{(IMG_H_LOG2-1){1'b1}}, 1'b0};
`endif

  state_t                  state_q, state_d;
  logic [IMG_W_LOG2-1:0]   x_q, x_d;
  logic [IMG_H_LOG2-1:0]   y_q, y_d;
  logic [3:0]              req_cnt_q, req_cnt_d;  // requests transferred for this pixel
  logic [7:0]              code_q, code_d;
  logic                    pend_q;                // a datum arrives this cycle
  logic [3:0]              rd_idx_q;              // window index of that datum
  logic [PIX_W-1:0]        centre_q;
  logic [PIX_W-1:0]        thr_q;

  logic                    start_ok;
  logic                    req_fire;
  logic [IMG_W_LOG2-1:0]   nx;
  logic [IMG_H_LOG2-1:0]   ny;
  logic [PIX_W:0]          thr_sum;
  logic                    nbr_ge;

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign gray_req = (state_q == S_FETCH) && (req_cnt_q < 4'd9);
  assign req_fire = gray_req && gray_ready;

  // Threshold is formed one bit wider so centre+offset never wraps; an
  // overflowing threshold simply makes every neighbour compare false.
  assign thr_sum = {1'b0, centre_q} + {1'b0, thr_q};
  assign nbr_ge  = {1'b0, gray_data} >= thr_sum;

  assign lbp_valid = (state_q == S_OUT);
  assign lbp_addr  = lbp_valid ? {y_q, x_q} : '0;
  assign lbp_data  = lbp_valid ? code_q : 8'h00;
  assign busy      = (state_q == S_FETCH) || (state_q == S_OUT);
  assign finish    = (state_q == S_DONE);
  assign gray_addr = gray_req ? {ny, nx} : '0;

  // Window address for the next request: centre first, then g0..g7.
  always_comb begin
    ny = y_q;
    nx = x_q;
    case (req_cnt_q)
      4'd1: begin ny = y_q - Y_ONE; nx = x_q - X_ONE; end
      4'd2: begin ny = y_q - Y_ONE; end
      4'd3: begin ny = y_q - Y_ONE; nx = x_q + X_ONE; end
      4'd4: begin nx = x_q - X_ONE; end
      4'd5: begin nx = x_q + X_ONE; end
      4'd6: begin ny = y_q + Y_ONE; nx = x_q - X_ONE; end
      4'd7: begin ny = y_q + Y_ONE; end
      4'd8: begin ny = y_q + Y_ONE; nx = x_q + X_ONE; end
      default: ;
    endcase
  end

  // Next-state logic: frame start, window fetch/compare, output handshake and scan advance.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    req_cnt_d = req_cnt_q;
    code_d    = code_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          code_d    = 8'h00;
          req_cnt_d = 4'd0;
`ifdef LBP_BORDER_EN
          x_d     = '0;
          y_d     = '0;
          state_d = S_OUT;
`else
          x_d     = X_ONE;
          y_d     = Y_ONE;
          state_d = S_FETCH;
`endif
        end
      end
      S_FETCH: begin
        if (req_fire) req_cnt_d = req_cnt_q + 4'd1;
        if (pend_q && (rd_idx_q != 4'd0)) begin
          code_d[rd_idx_q[2:0] - 3'd1] = nbr_ge;
          if (rd_idx_q == 4'd8) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (lbp_ready) begin
`ifdef LBP_BORDER_EN
          if ((x_q == X_MAX) && (y_q == Y_MAX)) begin
            state_d = S_DONE;
          end else begin
            if (x_q == X_MAX) begin
              x_d = '0;
              y_d = y_q + Y_ONE;
            end else begin
              x_d = x_q + X_ONE;
            end
            code_d    = 8'h00;
            req_cnt_d = 4'd0;
            if ((x_d == '0) || (x_d == X_MAX) || (y_d == '0) || (y_d == Y_MAX))
              state_d = S_OUT;
            else
              state_d = S_FETCH;
          end
`else
          if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
            state_d = S_DONE;
          end else begin
            if (x_q == X_LAST) begin
              x_d = X_ONE;
              y_d = y_q + Y_ONE;
            end else begin
              x_d = x_q + X_ONE;
            end
            code_d    = 8'h00;
            req_cnt_d = 4'd0;
            state_d   = S_FETCH;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      x_q       <= X_ONE;
      y_q       <= Y_ONE;
      req_cnt_q <= 4'd0;
      code_q    <= 8'h00;
      pend_q    <= 1'b0;
      rd_idx_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      req_cnt_q <= req_cnt_d;
      code_q    <= code_d;
      pend_q    <= req_fire;
      if (req_fire) rd_idx_q <= req_cnt_q;
    end
  end

  // Data registers: offset latched on an accepted start, centre on its read return.
  always_ff @(posedge clk) begin
    if (start_ok) thr_q <= thr_offset;
    if (pend_q && (rd_idx_q == 4'd0)) centre_q <= gray_data;
  end

endmodule

// File: tb/tb_lbp_engine_param.sv
// Directed bench for lbp_engine_param on an 8x8 image with a 1-cycle memory model.
module tb_lbp_engine_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] thr_offset = 8'h00;
  logic [5:0] gray_addr;
  logic       gray_req;
  logic       gray_ready = 1'b1;
  logic [7:0] gray_data = 8'h00;
  logic [5:0] lbp_addr;
  logic [7:0] lbp_data;
  logic       lbp_valid;
  logic       lbp_ready = 1'b1;
  logic       busy;
  logic       finish;

`ifdef LBP_BORDER_EN
  localparam int  NPIX   = 64;
  localparam bit  BORDER = 1'b1;
`else
  localparam int  NPIX   = 36;
  localparam bit  BORDER = 1'b0;
`endif

  logic [7:0] mem [64];
  int         thr_cur = 0;
  logic [5:0] xfer_q [$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] code18;

  lbp_engine_param #(.IMG_W_LOG2(3), .IMG_H_LOG2(3), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .thr_offset(thr_offset),
    .gray_addr(gray_addr), .gray_req(gray_req), .gray_ready(gray_ready),
    .gray_data(gray_data), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .lbp_valid(lbp_valid), .lbp_ready(lbp_ready), .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data valid the cycle after an accepted request.
  always @(posedge clk) if (gray_req && gray_ready) gray_data <= mem[gray_addr];

  // Log every transferred read address.
  always @(negedge clk) if (gray_req && gray_ready) xfer_q.push_back(gray_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bdr(input int a);
    int y = a / 8;
    int x = a % 8;
    return BORDER && (x == 0 || x == 7 || y == 0 || y == 7);
  endfunction

  function automatic int exp_addr(input int p);
    if (BORDER) return p;
    return ((p / 6) + 1) * 8 + (p % 6) + 1;
  endfunction

  function automatic int nbr(input int a, input int k);
    int dy[9];
    int dx[9];
    dy = '{0, -1, -1, -1, 0, 0, 1, 1, 1};
    dx = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
    return (a / 8 + dy[k]) * 8 + (a % 8) + dx[k];
  endfunction

  function automatic logic [7:0] lbp_model(input int a);
    logic [7:0] r = 8'h00;
    int thr;
    if (is_bdr(a)) return 8'h00;
    thr = int'(mem[a]) + thr_cur;
    for (int k = 0; k < 8; k++) r[k] = (int'(mem[nbr(a, k + 1)]) >= thr);
    return r;
  endfunction

  task automatic fill_pattern();
    for (int i = 0; i < 64; i++) mem[i] = 8'((i * 37 + 11) & 255);
  endtask

  task automatic set_window(input logic [7:0] c);
    mem[18] = c;   mem[9]  = 8'd99;  mem[10] = 8'd100; mem[11] = 8'd101;
    mem[17] = 8'd0; mem[19] = 8'd255; mem[25] = 8'd100; mem[26] = 8'd50;
    mem[27] = 8'd150;
  endtask

  task automatic start_frame(input logic [7:0] t);
    thr_cur = int'(t);
    xfer_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    thr_offset = t;
    @(posedge clk); #1;
    start = 1'b0;
    thr_offset = ~t;
    check("start_finish_clr", finish, 0);
    check("start_busy", busy, 1);
  endtask

  task automatic check_latency();
`ifndef LBP_BORDER_EN
    int lat = 0;
    while (!lbp_valid && lat < 100) begin
      @(negedge clk);
      if (!lbp_valid) lat++;
    end
    check("first_valid_latency", lat, 10);
`endif
  endtask

  // Accept all outputs of a frame, checking order, code and the read sequence.
  task automatic collect();
    int p = 0;
    int guard = 0;
    bit ok;
    int a;
    while (p < NPIX && guard < 20000) begin
      if (lbp_valid && lbp_ready) begin
        a = exp_addr(p);
        check("lbp_addr", lbp_addr, a);
        check("lbp_data", lbp_data, lbp_model(a));
        if (a == 18) code18 = lbp_data;
        ok = 1'b1;
        if (xfer_q.size() != (is_bdr(a) ? 0 : 9)) ok = 1'b0;
        else for (int k = 0; k < xfer_q.size(); k++)
          if (int'(xfer_q[k]) != nbr(a, k)) ok = 1'b0;
        check("fetch_seq", ok, 1);
        xfer_q.delete();
        p++;
      end
      @(negedge clk);
      guard++;
    end
    check("frame_len", p, NPIX);
    check("done_finish", finish, 1);
    check("done_busy", busy, 0);
    check("done_valid", lbp_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'd50;
    code18 = 8'hxx;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gray_req", gray_req, 0);
    check("rst_gray_addr", gray_addr, 0);
    check("rst_lbp_valid", lbp_valid, 0);
    check("rst_lbp_addr", lbp_addr, 0);
    check("rst_lbp_data", lbp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    reset = 1'b1;

    // Flat image: every neighbour equals the centre
    start_frame(8'd0);
    check_latency();
    collect();
    check("flat_code18", code18, 8'hFF);

    // Directed window, offset 0
    fill_pattern();
    set_window(8'd100);
    start_frame(8'd0);
    collect();
    check("win_thr0", code18, 8'b1011_0110);

    // Same window, offset 1
    start_frame(8'd1);
    collect();
    check("win_thr1", code18, 8'b1001_0100);

    // Threshold overflow
    set_window(8'd250);
    start_frame(8'd10);
    collect();
    check("win_ovf", code18, 8'h00);

`ifndef LBP_BORDER_EN
    // Memory and sink backpressure on the first pixel
    set_window(8'd100);
    lbp_ready = 1'b0;
    start_frame(8'd0);
    repeat (4) @(posedge clk);
    #1;
    gray_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req", gray_req, 1);
      check("stall_addr", gray_addr, 8);
      @(posedge clk); #1;
      start = 1'b0;
    end
    gray_ready = 1'b1;
    for (int g = 0; g < 50 && !lbp_valid; g++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("bp_addr", lbp_addr, 9);
      check("bp_data", lbp_data, lbp_model(9));
      @(negedge clk);
    end
    lbp_ready = 1'b1;
    collect();
`endif

    // Reset in the middle of the fetch for pixel (3,4)
    fill_pattern();
    start_frame(8'd3);
    for (int g = 0; g < 2000 && !(lbp_valid && lbp_addr == 6'd27); g++) @(negedge clk);
    check("reach_27", lbp_addr, 27);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_gray_req", gray_req, 0);
    check("abort_gray_addr", gray_addr, 0);
    check("abort_lbp_valid", lbp_valid, 0);
    check("abort_lbp_addr", lbp_addr, 0);
    check("abort_lbp_data", lbp_data, 0);
    check("abort_busy", busy, 0);
    check("abort_finish", finish, 0);
    reset = 1'b1;
    begin
      int reqs = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (gray_req) reqs++;
      end
      check("idle_no_req", reqs, 0);
    end
    start_frame(8'd0);
    check_latency();
    collect();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lbp_engine_param.md
Name: lbp_engine_param

Overview:
- Parametrised Local Binary Pattern engine for the image-feature pipeline.
- Scans a 2^IMG_W_LOG2 x 2^IMG_H_LOG2 grayscale image held in external synchronous memory, fetching each pixel's 3x3 window over a request/ready port.
- Emits one 8-bit LBP code per pixel over a valid/ready output port.
- Adds over the previous generation: generic image/pixel widths, a programmable comparison offset, a start pulse, output backpressure and a restartable done state.

Parameters:
- IMG_W_LOG2, 7, log2 of image width.
- IMG_H_LOG2, 7, log2 of image height.
- PIX_W, 8, gray pixel width in bits.
- ADDR_W, IMG_W_LOG2+IMG_H_LOG2, derived; do not override.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle or done.
- thr_offset  in  PIX_W  comparison offset, sampled on an accepted start.
- gray_addr  out  ADDR_W  read address {y,x}.
- gray_req  out  1  read request.
- gray_ready  in  1  memory accepts a request this cycle.
- gray_data  in  PIX_W  read data; valid exactly 1 cycle after an accepted request.
- lbp_addr  out  ADDR_W  output address {y,x}.
- lbp_data  out  8  LBP code.
- lbp_valid  out  1  output valid.
- lbp_ready  in  1  sink accepts output.
- busy  out  1  frame in progress.
- finish  out  1  frame complete; sticky until next start or reset.

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; x=y=1; gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, busy=0, finish=0. Reset mid-frame aborts immediately; no further requests are issued.
- States: IDLE, FETCH, OUT, DONE.
  - IDLE/DONE + start -> FETCH at x=y=1; thr_offset latched; finish cleared.
  - start while in FETCH or OUT is ignored.
- FETCH issues 9 requests in this order: centre (y,x), then g0..g7 = (y-1,x-1), (y-1,x), (y-1,x+1), (y,x-1), (y,x+1), (y+1,x-1), (y+1,x), (y+1,x+1).
  - A request transfers when gray_req && gray_ready. gray_req and gray_addr are held stable until transfer; gray_ready low stalls the sequence.
  - gray_data is captured on the cycle after each transfer.
- LBP arithmetic:
  - lbp_data[k] = (gk >= centre + thr_offset), evaluated at PIX_W+1 bits with no wrap. If centre+thr_offset > 2^PIX_W-1, every bit is 0.
  - Bit 0 is g0; bit 7 is g7.
- Timing: with gray_ready constantly high, the 9 transfers occur on FETCH cycles 0..8, the last datum arrives on cycle 9, and lbp_valid rises on cycle 10.
- OUT: lbp_valid=1 with lbp_addr={y,x}. lbp_addr and lbp_data are held until lbp_valid && lbp_ready.
  - On acceptance: if x == 2^IMG_W_LOG2-2, then x=1, y+1; otherwise x+1.
  - After the acceptance of pixel (H-2, W-2), go to DONE; otherwise return to FETCH.
- DONE: finish=1, busy=0, lbp_valid=0.
- busy=1 in FETCH and OUT only.
- Border pixels (x or y equal to 0 or max) are never addressed or output. Addresses never wrap.

Optional Feature:
- Macro LBP_BORDER_EN.
- When defined:
  - Scan covers every pixel from (0,0) to (H-1,W-1), raster order.
  - Border pixels skip FETCH entirely and go to OUT with lbp_data=0. The IDLE->OUT transition for pixel (0,0) is immediate.
  - DONE follows acceptance of address 2^ADDR_W-1.
- When undefined: interior-only scan as described in Behaviour. No border logic is synthesised.

Test Plan:
- IMG_W_LOG2=IMG_H_LOG2=3, flat image (all pixels 50), thr_offset=0, gray_ready=lbp_ready=1, start pulse -> 36 outputs at addresses 9..54, each lbp_data=8'hFF, first lbp_valid 10 cycles after FETCH entry; finish=1 after address 54 is accepted.
- Centre (2,2)=100, neighbours g0..g7 = 99, 100, 101, 0, 255, 100, 50, 150, thr_offset=0 -> lbp_data at lbp_addr 18 is 8'b1011_0110.
- Same window, thr_offset=1 -> lbp_data=8'b1001_0100. Centre=250, thr_offset=10 -> lbp_data=8'h00 (overflow clamps).
- gray_ready low for 3 cycles on the 5th request -> gray_addr and gray_req held, no skipped or duplicated address, code unchanged; lbp_ready low 4 cycles -> lbp_addr and lbp_data stable, x/y not advanced.
- reset driven low mid-FETCH at pixel (3,4) -> next cycle all outputs 0, state IDLE; a new start scans again from address 9.
- LBP_BORDER_EN, 8x8 image -> 64 outputs at addresses 0..63, border codes 0, no gray_req for any border pixel; finish after address 63.
